// File: rtl/exe2mem_if.sv
// exe2mem_if: ID/EXE bundle in, EXE/MEM bundle plus PC redirect out.
// EXE_FWD_EN adds the MEM/WB forwarding sources.
interface exe2mem_if;
  logic [162:0] in;
  logic stall;
  logic [71:0] out;
  logic redirect;
  logic [31:0] target;
  logic flush;
`ifdef EXE_FWD_EN
  logic mem_regwrite;
  logic [4:0] mem_wreg;
  logic [31:0] mem_res;
  logic wb_regwrite;
  logic [4:0] wb_wreg;
  logic [31:0] wb_res;
  modport master (
    output in, stall, mem_regwrite, mem_wreg, mem_res, wb_regwrite, wb_wreg, wb_res,
    input out, redirect, target, flush
  );
  modport slave (
    input in, stall, mem_regwrite, mem_wreg, mem_res, wb_regwrite, wb_wreg, wb_res,
    output out, redirect, target, flush
  );
`else
  modport master (output in, stall, input out, redirect, target, flush);
  modport slave (input in, stall, output out, redirect, target, flush);
`endif
endinterface

// File: rtl/exe2mem.sv
// exe2mem: EXE stage ALU, beq/j resolution and EXE/MEM register.
// EXE_FWD_EN enables MEM/WB forwarding of the Rs/Rt operands.
module exe2mem #(
  parameter int BUS_W = 163,
  parameter int OUT_W = 72
) (
  input logic clk,
  input logic clrn,
  exe2mem_if.slave bus
);
  logic [BUS_W-1:0] b;
  logic reg_write, mem_to_reg, mem_write, branch_eq, jump, alu_src, reg_dst;
  logic [2:0] alu_c;
  logic [4:0] rt, rd, rs, wreg;
  logic [15:0] imm;
  logic [25:0] adr;
  logic [31:0] qa_raw, qb_raw, qa, qb, pc4, sext, opb, alu_res, btarget, jtarget;
  logic zero, taken;
  logic [OUT_W-1:0] nxt_out;
  assign b = bus.in;
  assign {rs, adr, pc4, qb_raw, qa_raw, imm, rd, rt, alu_c, reg_dst, alu_src, jump,
          branch_eq, mem_write, mem_to_reg, reg_write} = b;
`ifdef EXE_FWD_EN
  // MEM result is younger than WB, so it takes priority
  assign qa = (rs != 5'd0 && bus.mem_regwrite && bus.mem_wreg == rs) ? bus.mem_res :
              (rs != 5'd0 && bus.wb_regwrite && bus.wb_wreg == rs) ? bus.wb_res : qa_raw;
  assign qb = (rt != 5'd0 && bus.mem_regwrite && bus.mem_wreg == rt) ? bus.mem_res :
              (rt != 5'd0 && bus.wb_regwrite && bus.wb_wreg == rt) ? bus.wb_res : qb_raw;
`else
  logic unused_rs;
  assign unused_rs = ^rs;
  assign qa = qa_raw;
  assign qb = qb_raw;
`endif
  assign sext = {{16{imm[15]}}, imm};
  assign opb = alu_src ? sext : qb;
  assign zero = (qa - qb) == 32'd0;
  assign wreg = reg_dst ? rd : rt;
  always_comb begin
    alu_res = 32'd0;
    case (alu_c)
      3'b000: alu_res = qa + opb;
      3'b001: alu_res = qa - opb;
      3'b010: alu_res = qa & opb;
      3'b011: alu_res = qa | opb;
      3'b100: alu_res = qa ^ opb;
      3'b101: alu_res = {31'd0, $signed(qa) < $signed(opb)};
      3'b110: alu_res = {imm, 16'd0};
      default: alu_res = opb << qa[4:0];
    endcase
  end
  assign btarget = pc4 + {sext[29:0], 2'b00};
  assign jtarget = {pc4[31:28], adr, 2'b00};
  assign taken = jump | (branch_eq & zero);
  assign nxt_out = {qb, alu_res, wreg, mem_write, mem_to_reg, reg_write};
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.out <= '0;
      bus.redirect <= 1'b0;
      bus.target <= 32'd0;
    end else begin
      if (!bus.stall) bus.out <= nxt_out;
      bus.redirect <= !bus.stall && taken;
      bus.target <= (!bus.stall && taken) ? (jump ? jtarget : btarget) : 32'd0;
    end
  end
  assign bus.flush = bus.redirect;
endmodule

// File: doc/exe2mem.md
Name: exe2mem

Overview:
- EXE-stage consumer of the 163-bit ID/EXE bundle.
- Unpacks the bundle fields, performs the ALU operation, and resolves beq and j.
- Registers the surviving control, result and store data into a packed 72-bit EXE/MEM bundle for the MEM stage.
- Drives the PC redirect and the flushCtrl request back to fetch/decode and the ID/EXE register.

Parameters:
- BUS_W, 163, input bundle width (fixed layout below)
- OUT_W, 72, output bundle width

Ports:
- clk  input  1  rising-edge clock
- clrn  input  1  asynchronous active-low reset
- in  input  163  ID/EXE bundle: [0]RegWrite [1]MemToReg [2]MemWrite [3]BranchEq [4]Jump [5]ALUSrc [6]RegDst [9:7]ALUc [14:10]Rt [19:15]Rd [35:20]imm [67:36]qa [99:68]qb [131:100]pc4 [157:132]adr [162:158]Rs
- stall  input  1  hold EXE/MEM register, suppress redirect
- out  output  72  [0]RegWrite [1]MemToReg [2]MemWrite [7:3]wreg [39:8]alu_res [71:40]store_data
- redirect  output  1  PC must load target (registered)
- target  output  32  redirect address (registered)
- flush  output  1  to ID/EXE flushCtrl and IF/ID clear (equals redirect)

Behaviour:
- Reset (clrn=0, async): out=0, redirect=0, target=0, flush=0. Reset is honoured mid-operation at any cycle.
- Operand A = qa. Operand B = ALUSrc ? sext(imm) : qb. sext replicates imm[15].
- ALUc encoding:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed, result 0/1)
  - 110 lui (imm<<16, A ignored)
  - 111 sll (B << qa[4:0])
- All arithmetic is mod 2^32; no overflow trap.
- zero = (qa - qb)==0, always computed on qb, independent of ALUSrc.
- wreg = RegDst ? Rd : Rt.
- Taken conditions:
  - Branch taken = BranchEq & zero; btarget = pc4 + (sext(imm)<<2).
  - Jump taken = Jump; jtarget = {pc4[31:28], adr, 2'b00}.
  - If Jump and BranchEq are both set, Jump wins.
- Registered update, one cycle latency, when stall=0:
  - out <= {qb, alu_res, wreg, MemWrite, MemToReg, RegWrite}.
  - redirect <= taken; target <= taken ? selected target : 0.
- When stall=1: out holds its value; redirect and target are forced to 0 next cycle, so no redirect fires while stalled.
- A stalled branch resolves on the first non-stall cycle, as long as the ID/EXE bundle is still held.
- flush is the same signal as redirect. It is asserted for exactly one cycle per taken branch/jump.
- All-zero bubble input: out=0, no redirect. RegWrite=0 is preserved, so nothing is written.
- Consecutive taken instructions each produce a one-cycle redirect. The second one cannot occur in practice because flush bubbles it, but the block shall not merge or drop it.
- wreg=0 is passed through unchanged; write suppression is the register file's job.

Optional Feature:
- Macro EXE_FWD_EN.
- When defined, six extra inputs are added:
  - mem_regwrite(1), mem_wreg(5), mem_res(32)
  - wb_regwrite(1), wb_wreg(5), wb_res(32)
- Forwarding of the Rs operand (qa):
  - Rs!=0 and mem_regwrite and mem_wreg==Rs: qa is replaced by mem_res.
  - Otherwise, wb match under the same rules: qa is replaced by wb_res.
  - MEM has priority over WB.
- Rt/qb is forwarded identically. The forwarded qb feeds operand B, zero and store_data.
- When undefined: no extra ports; raw qa/qb are used.

Test Plan:
- clrn low mid-stream with in=add bundle -> out=0, redirect=0 immediately (asynchronously); first edge after clrn rises registers the add normally.
- add: qa=5, qb=7, ALUc=000, RegDst=1, Rd=3, RegWrite=1 -> next cycle out[39:8]=12, out[7:3]=3, out[0]=1, redirect=0.
- beq taken: qa=qb=9, BranchEq=1, pc4=0x100, imm=0xFFFE -> redirect=1, target=0xF8 for one cycle, flush=1. With qb=8 -> redirect=0.
- j: pc4=0x40000010, adr=0x0000040 -> target=0x40000100; Jump plus BranchEq with equal operands -> jump target wins.
- stall=1 during beq taken -> out unchanged, redirect=0. Stall released with the same bundle -> redirect=1 next cycle.
- EXE_FWD_EN: Rs=4, mem_wreg=4 (mem_res=100), wb_wreg=4 (wb_res=200), add imm 1 -> alu_res=101. Repeat with mem_regwrite=0 -> 201. Repeat with Rs=0 -> uses qa.
